traffic_intersection_scheduler: RTL

TRAFFIC_INTERSECTION_SCHEDULER -- requirements
Module: traffic_intersection_scheduler

---
 rtl/traffic_intersection_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_scheduler.sv
// Two-approach intersection scheduler with a pedestrian walk phase.
// The six-phase FSM drives all lamps as a pure decode of the current phase.
// A single phase counter times every phase. It saturates while a green rests,
// so a late demand hands over on the very next edge.
//
// phase     | code | meaning
// ----------+------+---------------------------------------------------
// ALL_RED   |  0   | clearance; all approaches red, no walk
// NS_GREEN  |  1   | north-south green, rests until demand after minimum
// NS_YELLOW |  2   | north-south yellow, fixed duration
// EW_GREEN  |  3   | east-west green, rests until demand after minimum
// EW_YELLOW |  4   | east-west yellow, fixed duration
// WALK      |  5   | pedestrian walk, both approaches red
module traffic_intersection_scheduler #(
  parameter int GREEN_MIN = 500_000_000,
  parameter int YELLOW_T  = 300_000_000,
  parameter int ALLRED_T  = 100_000_000,
  parameter int WALK_T    = 500_000_000,
  parameter int CNT_W     = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_btn,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [2:0] ST_ALL_RED   = 3'd0;
  localparam logic [2:0] ST_NS_GREEN  = 3'd1;
  localparam logic [2:0] ST_NS_YELLOW = 3'd2;
  localparam logic [2:0] ST_EW_GREEN  = 3'd3;
  localparam logic [2:0] ST_EW_YELLOW = 3'd4;
  localparam logic [2:0] ST_WALK      = 3'd5;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Terminal counts: a phase of T cycles exits when the counter reads T-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dir_q, last_dir_d;
  logic             from_walk_q, from_walk_d;
  logic             ped_pending_q, ped_pending_d;

  logic in_green;
  logic green_done;
  logic state_change;
  logic walk_entry;

  assign in_green     = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);
  assign green_done   = (cnt_q == GREEN_LAST);
  assign state_change = (state_d != state_q);
  assign walk_entry   = (state_d == ST_WALK) && (state_q != ST_WALK);

  // Next-phase selection and bookkeeping of which approach was served last.
  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    from_walk_d = from_walk_q;
    case (state_q)
      ST_ALL_RED: begin
        if (cnt_q == ALLRED_LAST) begin
          // A pedestrian is served once between greens; after a walk the
          // opposite approach always gets its turn, even with no demand.
          if (ped_pending_q && !from_walk_q) begin
            state_d = ST_WALK;
          end else if (last_dir_q == DIR_EW) begin
            state_d = ST_NS_GREEN;
          end else begin
            state_d = ST_EW_GREEN;
          end
        end
      end
      ST_NS_GREEN: begin
        if (green_done && (ew_req || ped_pending_q)) begin
          state_d = ST_NS_YELLOW;
        end
      end
      ST_NS_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          state_d     = ST_ALL_RED;
          last_dir_d  = DIR_NS;
          from_walk_d = 1'b0;
        end
      end
      ST_EW_GREEN: begin
        if (green_done && (ns_req || ped_pending_q)) begin
          state_d = ST_EW_YELLOW;
        end
      end
      ST_EW_YELLOW: begin
        if (cnt_q == YELLOW_LAST) begin
          state_d     = ST_ALL_RED;
          last_dir_d  = DIR_EW;
          from_walk_d = 1'b0;
        end
      end
      ST_WALK: begin
        if (cnt_q == WALK_LAST) begin
          state_d     = ST_ALL_RED;
          from_walk_d = 1'b1;
        end
      end
      default: begin
        // Unused encodings fall back to the safe clearance phase.
        state_d = ST_ALL_RED;
      end
    endcase
  end

  // Phase timer: restarts on every phase change, holds at the green minimum.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_change) begin
      cnt_d = '0;
    end else if (in_green && green_done) begin
      cnt_d = cnt_q;
    end
  end

  // Pedestrian latch: cleared when the walk starts, button ignored during walk.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (walk_entry) begin
      ped_pending_d = 1'b0;
    end else if (ped_btn && (state_q != ST_WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ALL_RED;
      cnt_q         <= '0;
      last_dir_q    <= DIR_EW;
      from_walk_q   <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_dir_q    <= last_dir_d;
      from_walk_q   <= from_walk_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Lamp decode straight from the current phase; one lamp per approach.
  always_comb begin
    ns_green  = (state_q == ST_NS_GREEN);
    ns_yellow = (state_q == ST_NS_YELLOW);
    ns_red    = !(ns_green || ns_yellow);
    ew_green  = (state_q == ST_EW_GREEN);
    ew_yellow = (state_q == ST_EW_YELLOW);
    ew_red    = !(ew_green || ew_yellow);
    walk      = (state_q == ST_WALK);
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule
